prga_fifo_write_buffer: RTL and testbench



---
 rtl/prga_fifo_write_buffer.sv | 127 ++++++++++++
 tb/tb_prga_fifo_write_buffer.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/prga_fifo_write_buffer.sv
// ============================================================================
// Module   : prga_fifo_write_buffer
// Brief    : Two-entry skid buffer in front of a prga_fifo write port. The
//            upstream full flag is decoded from state registers only, so the
//            FIFO full flag never reaches the producer combinationally.
//            Optional statistics counters: PRGA_FIFO_WRITE_BUFFER_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module prga_fifo_write_buffer #(
  parameter int DATA_WIDTH    = 32,
  parameter int COUNTER_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  // upstream producer side
  output logic                     full,
  input  logic                     wr,
  input  logic [DATA_WIDTH-1:0]    din,
  // downstream FIFO side
  input  logic                     full_i,
  output logic                     wr_i,
  output logic [DATA_WIDTH-1:0]    din_i
`ifdef PRGA_FIFO_WRITE_BUFFER_STATS_EN
  ,
  output logic [COUNTER_WIDTH-1:0] stall_cnt,
  output logic [COUNTER_WIDTH-1:0] drop_cnt
`endif
);

  if (DATA_WIDTH < 1) begin : g_bad_data_width
    $error("prga_fifo_write_buffer: DATA_WIDTH must be at least 1");
  end

  if (COUNTER_WIDTH < 1) begin : g_bad_counter_width
    $error("prga_fifo_write_buffer: COUNTER_WIDTH must be at least 1");
  end

  // Encoding is {valid_s, valid_h}; 2'b10 (skid without head) is illegal.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    TWO   = 2'b11
  } state_t;

  state_t                  r_state;
  logic [DATA_WIDTH-1:0]   r_data_h;
  logic [DATA_WIDTH-1:0]   r_data_s;

  logic                    w_valid_h;
  logic                    w_push;
  logic                    w_pop;

  assign w_valid_h = r_state[0];
  assign full      = (r_state == TWO);
  assign w_push    = wr & ~full;
  assign w_pop     = w_valid_h & ~full_i;

  assign wr_i      = w_pop;
  assign din_i     = r_data_h;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= EMPTY;
      r_data_h <= '0;
      r_data_s <= '0;
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_push) begin
            r_state  <= ONE;
            r_data_h <= din;
          end
        end
        ONE: begin
          if (w_push && w_pop) begin
            r_data_h <= din;
          end else if (w_push) begin
            r_state  <= TWO;
            r_data_s <= din;
          end else if (w_pop) begin
            r_state  <= EMPTY;
          end
        end
        TWO: begin
          // Upstream is held off while full, so only a drain can happen here.
          if (w_pop) begin
            r_state  <= ONE;
            r_data_h <= r_data_s;
          end
        end
        default: begin
          r_state <= EMPTY;
        end
      endcase
    end
  end

`ifdef PRGA_FIFO_WRITE_BUFFER_STATS_EN
  localparam logic [COUNTER_WIDTH-1:0] c_cnt_max = '1;

  logic [COUNTER_WIDTH-1:0] r_stall_cnt;
  logic [COUNTER_WIDTH-1:0] r_drop_cnt;

  // Both counters saturate rather than wrap so a long stall stays visible.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= '0;
      r_drop_cnt  <= '0;
    end else begin
      if (w_valid_h && full_i && (r_stall_cnt != c_cnt_max)) begin
        r_stall_cnt <= r_stall_cnt + 1'b1;
      end
      if (wr && full && (r_drop_cnt != c_cnt_max)) begin
        r_drop_cnt <= r_drop_cnt + 1'b1;
      end
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign drop_cnt  = r_drop_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_prga_fifo_write_buffer.sv
// ============================================================================
// Module   : tb_prga_fifo_write_buffer
// Brief    : Directed self-checking bench for prga_fifo_write_buffer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_prga_fifo_write_buffer;

  localparam int DW = 32;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          full;
  logic          wr;
  logic [DW-1:0] din;
  logic          full_i;
  logic          wr_i;
  logic [DW-1:0] din_i;
`ifdef PRGA_FIFO_WRITE_BUFFER_STATS_EN
  logic [CW-1:0] stall_cnt;
  logic [CW-1:0] drop_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  prga_fifo_write_buffer #(
    .DATA_WIDTH   (DW),
    .COUNTER_WIDTH(CW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .full     (full),
    .wr       (wr),
    .din      (din),
    .full_i   (full_i),
    .wr_i     (wr_i),
    .din_i    (din_i)
`ifdef PRGA_FIFO_WRITE_BUFFER_STATS_EN
    ,
    .stall_cnt(stall_cnt),
    .drop_cnt (drop_cnt)
`endif
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [DW-1:0] words [64];
    int sent;
    int recv;
    int cyc;
    logic acc;

    rst    = 1'b1;
    wr     = 1'b0;
    din    = '0;
    full_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_full",  32'(full),  32'd0);
    chk("rst_wr_i",  32'(wr_i),  32'd0);
    chk("rst_din_i", din_i,      32'd0);
    rst = 1'b0;
    tick();

    // Streaming at full rate
    for (int i = 1; i <= 16; i++) begin
      wr  = 1'b1;
      din = 32'(i);
      #1;
      chk("stream_full", 32'(full), 32'd0);
      if (i > 1) begin
        chk("stream_wr_i",  32'(wr_i), 32'd1);
        chk("stream_din_i", din_i,     32'(i - 1));
      end
      tick();
    end
    wr = 1'b0;
    #1;
    chk("stream_last_wr_i",  32'(wr_i), 32'd1);
    chk("stream_last_din_i", din_i,     32'h10);
    tick();
    #1;
    chk("stream_idle_wr_i", 32'(wr_i), 32'd0);

    // Backpressure skid
    wr = 1'b1; din = 32'hA0; full_i = 1'b0;
    #1;
    chk("skid_c1_full", 32'(full), 32'd0);
    tick();
    din = 32'hA1; full_i = 1'b1;
    #1;
    chk("skid_c2_wr_i", 32'(wr_i), 32'd0);
    chk("skid_c2_full", 32'(full), 32'd0);
    tick();
    din = 32'hA2;
    for (int c = 3; c <= 5; c++) begin
      #1;
      chk("skid_hold_full",  32'(full), 32'd1);
      chk("skid_hold_wr_i",  32'(wr_i), 32'd0);
      chk("skid_hold_din_i", din_i,     32'hA0);
      tick();
    end
    full_i = 1'b0;
    #1;
    chk("skid_c6_wr_i",  32'(wr_i), 32'd1);
    chk("skid_c6_din_i", din_i,     32'hA0);
    chk("skid_c6_full",  32'(full), 32'd1);
    tick();
    #1;
    chk("skid_c7_full",  32'(full), 32'd0);
    chk("skid_c7_wr_i",  32'(wr_i), 32'd1);
    chk("skid_c7_din_i", din_i,     32'hA1);
    tick();
    wr = 1'b0;
    #1;
    chk("skid_c8_wr_i",  32'(wr_i), 32'd1);
    chk("skid_c8_din_i", din_i,     32'hA2);
    tick();
    #1;
    chk("skid_c9_wr_i", 32'(wr_i), 32'd0);

    // Write while full (fresh counters)
    rst = 1'b1;
    #1;
    rst = 1'b0;
    full_i = 1'b1; wr = 1'b1; din = 32'hB0;
    tick();
    din = 32'hB1;
    tick();
    din = 32'hFF;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("wfull_full",  32'(full), 32'd1);
      chk("wfull_wr_i",  32'(wr_i), 32'd0);
      chk("wfull_din_i", din_i,     32'hB0);
      tick();
    end
    wr = 1'b0;
`ifdef PRGA_FIFO_WRITE_BUFFER_STATS_EN
    #1;
    chk("wfull_drop_cnt",  32'(drop_cnt),  32'd3);
    chk("wfull_stall_cnt", 32'(stall_cnt), 32'd4);
`endif
    full_i = 1'b0;
    #1;
    chk("wfull_drain0_wr_i",  32'(wr_i), 32'd1);
    chk("wfull_drain0_din_i", din_i,     32'hB0);
    tick();
    #1;
    chk("wfull_drain1_wr_i",  32'(wr_i), 32'd1);
    chk("wfull_drain1_din_i", din_i,     32'hB1);
    tick();
    #1;
    chk("wfull_drain2_wr_i", 32'(wr_i), 32'd0);

`ifdef PRGA_FIFO_WRITE_BUFFER_STATS_EN
    // Stall counter saturation with a 4-bit counter
    full_i = 1'b1; wr = 1'b1; din = 32'h33;
    tick();
    wr = 1'b0;
    repeat (20) tick();
    chk("sat_stall_cnt", 32'(stall_cnt), 32'd15);
    tick();
    chk("sat_stall_hold", 32'(stall_cnt), 32'd15);
    full_i = 1'b0;
    tick();
`endif

    // Async reset mid-operation
    full_i = 1'b1; wr = 1'b1; din = 32'hC0;
    tick();
    din = 32'hC1;
    tick();
    wr = 1'b0; full_i = 1'b0;
    #1;
    chk("arst_pre_full",  32'(full), 32'd1);
    chk("arst_pre_wr_i",  32'(wr_i), 32'd1);
    chk("arst_pre_din_i", din_i,     32'hC0);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_full",  32'(full), 32'd0);
    chk("arst_wr_i",  32'(wr_i), 32'd0);
    chk("arst_din_i", din_i,     32'd0);
    tick();
    rst = 1'b0;
    wr = 1'b1; din = 32'h5A;
    #1;
    chk("arst_post_wr_i", 32'(wr_i), 32'd0);
    tick();
    wr = 1'b0;
    #1;
    chk("arst_5a_wr_i",  32'(wr_i), 32'd1);
    chk("arst_5a_din_i", din_i,     32'h5A);
    tick();
    #1;
    chk("arst_idle_wr_i", 32'(wr_i), 32'd0);

    // Random words with full_i toggling every cycle
    for (int i = 0; i < 64; i++) words[i] = $urandom;
    sent = 0;
    recv = 0;
    cyc  = 0;
    while ((recv < 64) && (cyc < 1000)) begin
      full_i = ((cyc % 2) == 1);
      wr     = (sent < 64);
      din    = (sent < 64) ? words[sent] : '0;
      #1;
      if (wr_i) begin
        if (recv < 64) begin
          chk("rand_din_i", din_i, words[recv]);
        end else begin
          chk("rand_extra_wr_i", 32'(wr_i), 32'd0);
        end
        recv++;
      end
      acc = wr & ~full;
      tick();
      if (acc) sent++;
      cyc++;
    end
    wr = 1'b0; full_i = 1'b0;
    for (int c = 0; c < 4; c++) begin
      #1;
      chk("rand_tail_wr_i", 32'(wr_i), 32'd0);
      tick();
    end
    chk("rand_sent", 32'(sent), 32'd64);
    chk("rand_recv", 32'(recv), 32'd64);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
